// File: rtl/range_pkg.sv
// Shared types and constants for the RangeFinder session controller.
package range_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFirst,
        StBody,
        StWait,
        StResult
    } state_e;

    localparam int unsigned RF_LAT_DEF  = 1;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned MIN_COUNT   = 2;

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

endpackage

// File: rtl/range_session_ctrl_if.sv
// Host stream, RangeFinder pins and result handshake of the session controller.
interface range_session_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [7:0]       cfg_count;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_range;
    logic             rf_error;
    logic [WIDTH-1:0] res_range;
    logic             res_error;
    logic             res_timeout;
    logic             res_valid;
    logic             res_ack;
    logic             busy;

    modport slave (
        input  start, cfg_count, s_data, s_valid, rf_range, rf_error, res_ack,
        output s_ready, rf_data, rf_go, rf_finish, res_range, res_error, res_timeout,
               res_valid, busy
    );

    modport master (
        output start, cfg_count, s_data, s_valid, rf_range, rf_error, res_ack,
        input  s_ready, rf_data, rf_go, rf_finish, res_range, res_error, res_timeout,
               res_valid, busy
    );
endinterface

// File: rtl/idle_timer.sv
// Saturating idle counter; expire_o flags the cycle on which the count would reach LIMIT.
module idle_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q != 8'(LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign expire_o = en_i && !clear_i && (cnt_q == 8'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/range_session_ctrl.sv
// Runs one framed RangeFinder measurement session per start and holds the result until acked.
module range_session_ctrl
    import range_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RF_LAT  = RF_LAT_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input logic               clk,
    input logic               rst_n,
    range_session_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [1:0]       lat_q, lat_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] rf_data_q, rf_data_d;
    logic [WIDTH-1:0] res_range_q, res_range_d;
    logic             rf_go_q, rf_go_d;
    logic             rf_finish_q, rf_finish_d;
    logic             res_error_q, res_error_d;
    logic             res_timeout_q, res_timeout_d;
    logic             running, accept, expire;

    assign running = (state_q == StFirst) || (state_q == StBody);
    assign accept  = running && bus.s_valid;

    idle_timer #(
        .LIMIT(TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (accept),
        .en_i    (running),
        .expire_o(expire)
    );

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        lat_d         = '0;
        last_d        = last_q;
        rf_data_d     = rf_data_q;
        rf_go_d       = 1'b0;
        rf_finish_d   = 1'b0;
        res_range_d   = res_range_q;
        res_error_d   = res_error_q;
        res_timeout_d = res_timeout_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    res_range_d   = '0;
                    res_timeout_d = 1'b0;
                    if (bus.cfg_count >= 8'(MIN_COUNT)) begin
                        rem_d       = bus.cfg_count;
                        res_error_d = 1'b0;
                        state_d     = StFirst;
                    end else begin
                        res_error_d = 1'b1;
                        state_d     = StResult;
                    end
                end
            end
            StFirst: begin
                if (accept) begin
                    rf_data_d = bus.s_data;
                    rf_go_d   = 1'b1;
                    last_d    = bus.s_data;
                    rem_d     = sat_dec(rem_q);
                    state_d   = StBody;
                end else if (expire) begin
                    res_timeout_d = 1'b1;
                    res_error_d   = 1'b1;
                    res_range_d   = '0;
                    state_d       = StResult;
                end
            end
            StBody: begin
                if (accept) begin
                    rf_data_d = bus.s_data;
                    last_d    = bus.s_data;
                    rem_d     = sat_dec(rem_q);
                    if (rem_q == 8'd1) begin
                        rf_finish_d = 1'b1;
                        state_d     = StWait;
                    end
                end else if (expire) begin
                    // Close the frame by repeating the last sample; min/max are unaffected.
                    rf_data_d     = last_q;
                    rf_finish_d   = 1'b1;
                    res_timeout_d = 1'b1;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (lat_q == 2'(RF_LAT)) begin
                    res_range_d = bus.rf_range;
                    res_error_d = bus.rf_error;
                    state_d     = StResult;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StResult: begin
                if (bus.res_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rem_q         <= '0;
            lat_q         <= '0;
            last_q        <= '0;
            rf_data_q     <= '0;
            rf_go_q       <= 1'b0;
            rf_finish_q   <= 1'b0;
            res_range_q   <= '0;
            res_error_q   <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            lat_q         <= lat_d;
            last_q        <= last_d;
            rf_data_q     <= rf_data_d;
            rf_go_q       <= rf_go_d;
            rf_finish_q   <= rf_finish_d;
            res_range_q   <= res_range_d;
            res_error_q   <= res_error_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.s_ready     = running;
    assign bus.rf_data     = rf_data_q;
    assign bus.rf_go       = rf_go_q;
    assign bus.rf_finish   = rf_finish_q;
    assign bus.res_range   = res_range_q;
    assign bus.res_error   = res_error_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.res_valid   = (state_q == StResult);
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_range_session_ctrl.sv
// Self-checking bench for range_session_ctrl with a behavioural RangeFinder (RF_LAT = 1).
module tb_range_session_ctrl;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    range_session_ctrl_if #(.WIDTH(8)) bus ();

    range_session_ctrl #(
        .WIDTH  (8),
        .RF_LAT (1),
        .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // RangeFinder model: tracks min/max of every cycle between go and finish inclusive.
    logic [7:0] rfm_min, rfm_max, lo, hi;
    logic       rfm_active, rfm_err, inject;
    assign bus.rf_error = rfm_err | inject;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfm_active   <= 1'b0;
            rfm_min      <= '0;
            rfm_max      <= '0;
            rfm_err      <= 1'b0;
            bus.rf_range <= '0;
        end else if (bus.rf_go || rfm_active) begin
            if (bus.rf_go && rfm_active) rfm_err <= 1'b1;
            lo = bus.rf_go ? bus.rf_data : ((bus.rf_data < rfm_min) ? bus.rf_data : rfm_min);
            hi = bus.rf_go ? bus.rf_data : ((bus.rf_data > rfm_max) ? bus.rf_data : rfm_max);
            rfm_min <= lo;
            rfm_max <= hi;
            if (bus.rf_finish) begin
                rfm_active   <= 1'b0;
                bus.rf_range <= hi - lo;
            end else begin
                rfm_active <= 1'b1;
            end
        end else if (bus.rf_finish) begin
            rfm_err <= 1'b1;
        end
    end

    // Pulse monitor: running totals, sampled mid-cycle.
    int         go_cnt = 0, fin_cnt = 0;
    logic [7:0] go_data = '0, fin_data = '0;
    always @(negedge clk) begin
        if (bus.rf_go) begin
            go_cnt  <= go_cnt + 1;
            go_data <= bus.rf_data;
        end
        if (bus.rf_finish) begin
            fin_cnt  <= fin_cnt + 1;
            fin_data <= bus.rf_data;
        end
    end

    logic [7:0] g_smp [16];
    int         g_gap [16];
    int         go_base, fin_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Session-level reference: what the host should see, from the gap/sample plan alone.
    function automatic void ref_model(input int cnt, input logic inj, output logic [7:0] rng,
                                      output logic err, output logic tmo, output int acc,
                                      output logic [7:0] first_s, output logic [7:0] last_s);
        int mn = 255, mx = 0;
        rng = 0; err = 0; tmo = 0; acc = 0; first_s = 0; last_s = 0;
        if (cnt < 2) begin
            err = 1;
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            if (g_gap[i] >= int'(TMO)) begin
                tmo = 1;
                break;
            end
            acc++;
            if (int'(g_smp[i]) < mn) mn = int'(g_smp[i]);
            if (int'(g_smp[i]) > mx) mx = int'(g_smp[i]);
        end
        if (acc == 0) begin
            err = 1;
        end else begin
            rng     = 8'(mx - mn);
            err     = inj;
            first_s = g_smp[0];
            last_s  = g_smp[acc-1];
        end
    endfunction

    // Called at a negedge; leaves s_valid low at a negedge.
    task automatic run_offer(input int cnt, input int n);
        go_base = go_cnt;
        fin_base = fin_cnt;
        bus.start = 1'b1;
        bus.cfg_count = 8'(cnt);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b0;
            repeat (g_gap[i]) @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data = g_smp[i];
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic finish_session(input string name, input logic [7:0] rng, input logic err,
                                  input logic tmo, input logic exp_go, input logic [7:0] f_s,
                                  input logic [7:0] l_s);
        int t = 0;
        while (bus.res_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({name, " res_valid"}, bus.res_valid, 1);
        check({name, " res_range"}, bus.res_range, rng);
        check({name, " res_error"}, bus.res_error, err);
        check({name, " res_timeout"}, bus.res_timeout, tmo);
        check({name, " go_pulses"}, go_cnt - go_base, exp_go);
        check({name, " finish_pulses"}, fin_cnt - fin_base, exp_go);
        if (exp_go) begin
            check({name, " go_data"}, go_data, f_s);
            check({name, " finish_data"}, fin_data, l_s);
        end
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
        check({name, " valid_after_ack"}, bus.res_valid, 0);
        check({name, " busy_after_ack"}, bus.busy, 0);
    endtask

    typedef struct packed {
        logic [7:0]      cnt;
        logic [5:0][7:0] smp;  // element 0 is the rightmost byte
        logic [5:0][7:0] gap;
        logic [7:0]      rng;
        logic            err;
        logic            tmo;
    } vec_t;

    initial begin
        vec_t       vec [9];
        logic [7:0] e_rng, f_s, l_s;
        logic       e_err, e_tmo;
        int         acc, cnt;

        bus.start = 0; bus.cfg_count = 0; bus.s_data = 0; bus.s_valid = 0; bus.res_ack = 0;
        inject = 0;

        vec[0] = '{cnt: 8'd4, smp: {8'd0, 8'd0, 8'd50, 8'd200, 8'd3, 8'd10}, gap: '0,
                   rng: 8'd197, err: 1'b0, tmo: 1'b0};
        vec[1] = '{cnt: 8'd3, smp: {8'd0, 8'd0, 8'd0, 8'd7, 8'd7, 8'd7},
                   gap: {8'd0, 8'd0, 8'd0, 8'd5, 8'd5, 8'd0}, rng: 8'd0, err: 1'b0, tmo: 1'b0};
        vec[2] = '{cnt: 8'd5, smp: {8'd0, 8'd33, 8'd44, 8'd55, 8'd90, 8'd20},
                   gap: {8'd0, 8'd0, 8'd0, 8'd8, 8'd0, 8'd0}, rng: 8'd70, err: 1'b0, tmo: 1'b1};
        vec[3] = '{cnt: 8'd1, smp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd42}, gap: '0,
                   rng: 8'd0, err: 1'b1, tmo: 1'b0};
        vec[4] = '{cnt: 8'd0, smp: '0, gap: '0, rng: 8'd0, err: 1'b1, tmo: 1'b0};
        vec[5] = '{cnt: 8'd2, smp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd5}, gap: '0,
                   rng: 8'd4, err: 1'b0, tmo: 1'b0};
        vec[6] = '{cnt: 8'd3, smp: {8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1},
                   gap: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8}, rng: 8'd0, err: 1'b1, tmo: 1'b1};
        vec[7] = '{cnt: 8'd2, smp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd30, 8'd100},
                   gap: {8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd7}, rng: 8'd70, err: 1'b0, tmo: 1'b0};
        vec[8] = '{cnt: 8'd6, smp: {8'd77, 8'd255, 8'd0, 8'd128, 8'd1, 8'd250},
                   gap: {8'd0, 8'd1, 8'd0, 8'd2, 8'd0, 8'd3}, rng: 8'd255, err: 1'b0, tmo: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst s_ready", bus.s_ready, 0);
        check("rst busy", bus.busy, 0);
        check("rst res_valid", bus.res_valid, 0);
        check("rst rf_go", bus.rf_go, 0);
        check("rst rf_finish", bus.rf_finish, 0);
        check("rst res_range", bus.res_range, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back count 4 with cycle-exact framing, then a long un-acked hold
        bus.start = 1; bus.cfg_count = 4;
        @(negedge clk);
        bus.start = 0;
        check("seq_a first s_ready", bus.s_ready, 1);
        bus.s_valid = 1; bus.s_data = 10;
        @(negedge clk);
        check("seq_a go", bus.rf_go, 1);
        check("seq_a data0", bus.rf_data, 10);
        check("seq_a fin0", bus.rf_finish, 0);
        bus.s_data = 3;
        @(negedge clk);
        check("seq_a go1", bus.rf_go, 0);
        check("seq_a data1", bus.rf_data, 3);
        bus.s_data = 200;
        @(negedge clk);
        check("seq_a data2", bus.rf_data, 200);
        check("seq_a fin2", bus.rf_finish, 0);
        bus.s_data = 50;
        @(negedge clk);
        check("seq_a fin3", bus.rf_finish, 1);
        check("seq_a data3", bus.rf_data, 50);
        check("seq_a ready_wait", bus.s_ready, 0);
        check("seq_a valid_e0", bus.res_valid, 0);
        bus.s_valid = 0;
        @(negedge clk);
        check("seq_a fin_drop", bus.rf_finish, 0);
        check("seq_a valid_e1", bus.res_valid, 0);
        @(negedge clk);
        check("seq_a valid_e2", bus.res_valid, 1);
        for (int i = 0; i < 20; i++) begin
            bus.s_valid = 1; bus.s_data = 8'($urandom);
            @(negedge clk);
            check("hold res_valid", bus.res_valid, 1);
            check("hold res_range", bus.res_range, 197);
            check("hold res_error", bus.res_error, 0);
            check("hold res_timeout", bus.res_timeout, 0);
            check("hold s_ready", bus.s_ready, 0);
        end
        bus.s_valid = 0; bus.res_ack = 1;
        @(negedge clk);
        bus.res_ack = 0;
        check("seq_a ack valid", bus.res_valid, 0);

        // Table vectors
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 6; i++) begin
                g_smp[i] = vec[k].smp[i];
                g_gap[i] = int'(vec[k].gap[i]);
            end
            cnt = int'(vec[k].cnt);
            ref_model(cnt, 1'b0, e_rng, e_err, e_tmo, acc, f_s, l_s);
            run_offer(cnt, cnt);
            finish_session($sformatf("vec%0d", k), vec[k].rng, vec[k].err, vec[k].tmo,
                           acc > 0, f_s, l_s);
        end

        // Count 1: start pulses in RESULT must be ignored
        bus.start = 1; bus.cfg_count = 1;
        @(negedge clk);
        go_base = go_cnt; fin_base = fin_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.cfg_count = 4;
            @(negedge clk);
            check("cfg1 res_valid", bus.res_valid, 1);
            check("cfg1 res_error", bus.res_error, 1);
            check("cfg1 s_ready", bus.s_ready, 0);
        end
        bus.start = 0;
        finish_session("cfg1", 0, 1, 0, 0, 0, 0);

        // Asynchronous reset mid-BODY, then a fresh session
        g_smp[0] = 20; g_smp[1] = 30; g_gap[0] = 0; g_gap[1] = 0;
        run_offer(4, 2);
        check("pre_rst busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rf_data", bus.rf_data, 0);
        check("async busy", bus.busy, 0);
        check("async s_ready", bus.s_ready, 0);
        check("async rf_finish", bus.rf_finish, 0);
        check("async res_valid", bus.res_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        g_smp[0] = 5; g_smp[1] = 9;
        run_offer(2, 2);
        finish_session("after_rst", 4, 0, 0, 1, 5, 9);

        // Randomized sessions against the reference
        for (int s = 0; s < 40; s++) begin
            cnt = $urandom_range(0, 10);
            for (int i = 0; i < 16; i++) begin
                int r;
                r = $urandom_range(0, 9);
                g_smp[i] = 8'($urandom);
                if (r < 7) g_gap[i] = $urandom_range(0, 2);
                else if (r == 7) g_gap[i] = TMO - 1;
                else g_gap[i] = TMO + $urandom_range(0, 2);
            end
            inject = ($urandom_range(0, 3) == 0);
            ref_model(cnt, inject, e_rng, e_err, e_tmo, acc, f_s, l_s);
            run_offer(cnt, cnt);
            finish_session($sformatf("rand%0d", s), e_rng, e_err, e_tmo, acc > 0, f_s, l_s);
            inject = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
